// File: rtl/display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Time-multiplexed 7-segment display scanner. A prescaler
//                paces a digit index across DISPLAYS digits. New segment
//                data is staged in a pending buffer and promoted to the
//                displayed (active) register only at frame boundaries, so a
//                frame never mixes old and new data.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scanner #(
  parameter int DISPLAYS      = 2,
  parameter int SEGMENTS      = 7,
  parameter int DIV           = 50000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [SEGMENTS*DISPLAYS-1:0]                  sseg_in,
  input  logic                                          load,
  input  logic                                          en,
  output logic [SEGMENTS-1:0]                           seg,
  output logic [DISPLAYS-1:0]                           an,
  output logic [((DISPLAYS > 1) ? $clog2(DISPLAYS) : 1)-1:0] digit_idx,
  output logic                                          pending,
  output logic                                          frame_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_IDX_W  = (DISPLAYS > 1) ? $clog2(DISPLAYS) : 1;
  localparam int c_CNT_W  = $clog2(DIV);
  localparam int c_DATA_W = SEGMENTS * DISPLAYS;

  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(DIV - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DISPLAYS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0]  r_count;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_DATA_W-1:0] r_active;
  logic [c_DATA_W-1:0] r_pend_buf;
  logic                r_pending;
  logic                r_frame_done;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                w_tick;
  logic                w_boundary;
  logic                w_scan_on;
  logic [DISPLAYS-1:0] w_an_on;

  // A tick only exists while scanning is enabled, so en=0 freezes everything.
  assign w_tick     = en && (r_count == c_LAST_CNT);
  // The last digit finishing its slot closes the frame.
  assign w_boundary = w_tick && (r_idx == c_LAST_IDX);
  // Anodes are gated by rst_n as well so they blank immediately on reset,
  // even while en is still high and before any clock edge.
  assign w_scan_on  = en && rst_n;

  // Prescaler: counts enabled cycles, wraps after DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en) begin
      if (w_tick) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + c_CNT_W'(1);
      end
    end
  end

  // Digit index: advances once per tick, wrapping after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_tick) begin
      if (r_idx == c_LAST_IDX) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + c_IDX_W'(1);
      end
    end
  end

  // Staging buffer: every load overwrites it, last write wins. Loads are
  // accepted regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_buf <= '0;
    end else if (load) begin
      r_pend_buf <= sseg_in;
    end
  end

  // Pending flag and active register: promotion happens only at a frame
  // boundary. A load landing exactly on the boundary bypasses the buffer so
  // the new data appears in the very next frame with nothing left pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_active <= sseg_in;
      end else if (r_pending) begin
        r_active <= r_pend_buf;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_pending <= 1'b1;
    end
  end

  // Frame-done pulse: registered copy of the boundary, so it is high in the
  // cycle where the index has just returned to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (no added latency)
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DISPLAYS; gi++) begin : g_anode
      assign w_an_on[gi] = w_scan_on && (r_idx == c_IDX_W'(gi));
    end

    if (AN_ACTIVE_LOW != 0) begin : g_an_low
      assign an = ~w_an_on;
    end else begin : g_an_high
      assign an = w_an_on;
    end
  endgenerate

  assign seg        = r_active[int'(r_idx)*SEGMENTS +: SEGMENTS];
  assign digit_idx  = r_idx;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Scoreboard bench for display_scanner (DIV=4, DISPLAYS=2).
//                Stimulus pushes expected outputs from a frame-level model;
//                a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

  localparam int c_DIV   = 4;
  localparam int c_NDISP = 2;
  localparam int c_SEGS  = 7;
  localparam int c_FRAME = c_DIV * c_NDISP;

  logic        clk;
  logic        rst_n;
  logic [13:0] sseg_in;
  logic        load;
  logic        en;
  logic [6:0]  seg;
  logic [1:0]  an;
  logic [0:0]  digit_idx;
  logic        pending;
  logic        frame_done;

  display_scanner #(
    .DISPLAYS      (c_NDISP),
    .SEGMENTS      (c_SEGS),
    .DIV           (c_DIV),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sseg_in    (sseg_in),
    .load       (load),
    .en         (en),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       idx;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: position in the frame counted in enabled cycles.
  int          m_pos;
  logic [13:0] m_active;
  logic [13:0] m_buf;
  bit          m_pend;
  bit          m_fd;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [1:0] an_of(int idx, bit e);
    logic [1:0] v;
    v = 2'b11;
    if (e) v[idx] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_pos    = 0;
    m_active = '0;
    m_buf    = '0;
    m_pend   = 1'b0;
    m_fd     = 1'b0;
  endtask

  // One clock of stimulus: drive inputs for the coming edge, record what the
  // outputs must show until then, then advance the model across that edge.
  task automatic step(input bit e, input bit ld, input logic [13:0] s, input bit rel);
    exp_t x;
    int   idx;
    bit   bnd;
    @(posedge clk);
    #1;
    if (rel) rst_n = 1'b1;
    en      = e;
    load    = ld;
    sseg_in = s;
    idx     = m_pos / c_DIV;
    x.seg   = m_active[idx*c_SEGS +: c_SEGS];
    x.an    = an_of(idx, e);
    x.idx   = idx[0];
    x.pend  = m_pend;
    x.fd    = m_fd;
    sb_q.push_back(x);
    bnd  = e && (m_pos == c_FRAME - 1);
    if (e) m_pos = (m_pos + 1) % c_FRAME;
    m_fd = bnd;
    if (bnd) begin
      if (ld) m_active = s;
      else if (m_pend) m_active = m_buf;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_buf = s;
      if (!bnd) m_pend = 1'b1;
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge sees it.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_an", an, 2'b11);
    check("rst_pending", pending, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_seg", seg, 0);
    check("rst_idx", digit_idx, 0);
    model_reset();
    load    = 1'b1;
    sseg_in = 14'($urandom);
    repeat (2) @(posedge clk);
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("seg", seg, x.seg);
      check("an", an, x.an);
      check("digit_idx", digit_idx, x.idx);
      check("pending", pending, x.pend);
      check("frame_done", frame_done, x.fd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [13:0] s;
    bit          ld;
    bit          e;
    bit          rel;

    rst_n   = 1'b1;
    en      = 1'b1;
    load    = 1'b1;
    sseg_in = 14'h1555;
    #1;
    rst_n = 1'b0;
    #1;
    check("init_an", an, 2'b11);
    check("init_seg", seg, 0);
    check("init_pending", pending, 0);
    check("init_frame_done", frame_done, 0);
    check("init_idx", digit_idx, 0);
    model_reset();

    // Directed frame sequence: deferred update, last write wins, load on the
    // boundary edge (position 23 = 3*8-1), then an enable gap at count 2.
    for (int k = 0; k < 26; k++) begin
      ld = 1'b0;
      s  = 14'h0;
      case (k)
        1:  begin ld = 1'b1; s = {7'h06, 7'h3F}; end
        9:  begin ld = 1'b1; s = {7'h5B, 7'h4F}; end
        11: begin ld = 1'b1; s = {7'h66, 7'h6D}; end
        23: begin ld = 1'b1; s = {7'h07, 7'h7F}; end
        default: ;
      endcase
      step(1'b1, ld, s, k == 0);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, k == 5, {7'h39, 7'h5E}, 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 14'h0, 1'b0);
    end

    // Reset at frame cycle 5 with an update still pending.
    while (m_pos != 3) step(1'b1, 1'b0, 14'h0, 1'b0);
    step(1'b1, 1'b1, {7'h71, 7'h79}, 1'b0);
    step(1'b1, 1'b0, 14'h0, 1'b0);
    reset_pulse();
    step(1'b1, 1'b0, 14'h0, 1'b1);

    // Randomized traffic with occasional resets.
    rel = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (($urandom % 300) == 0) begin
        reset_pulse();
        rel = 1'b1;
      end
      e  = (($urandom % 8) != 0);
      ld = (($urandom % 5) == 0);
      s  = 14'($urandom);
      step(e, ld, s, rel);
      rel = 1'b0;
    end

    @(negedge clk);
    #1;
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL provide parameter DISPLAYS, default 2: number of multiplexed 7-segment digits.
REQ-002 SHALL provide parameter SEGMENTS, default 7: segment lines per digit.
REQ-003 SHALL provide parameter DIV, default 50000: clock cycles each digit stays lit; legal range 2 or more.
REQ-004 SHALL provide parameter AN_ACTIVE_LOW, default 1: when 1, the enabled anode is driven 0.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 sseg_in  input  SEGMENTS*DISPLAYS  packed segment patterns from the BCD-to-segment decoder; digit 0 (units) is the LSB slice.
REQ-009 load  input  1  capture strobe for sseg_in, sampled on every rising clk edge.
REQ-010 en  input  1  scan enable.
REQ-011 seg  output  SEGMENTS  segment pattern for the currently selected digit.
REQ-012 an  output  DISPLAYS  one-hot anode select, polarity set by AN_ACTIVE_LOW.
REQ-013 digit_idx  output  clog2(DISPLAYS), minimum 1  current digit index.
REQ-014 pending  output  1  a captured update is waiting for the next frame boundary.
REQ-015 frame_done  output  1  one-cycle pulse after the last digit of a frame.

Function
REQ-016 Prescaler SHALL count 0..DIV-1 while en=1, wrap to 0, and raise an internal tick in the cycle where the count equals DIV-1.
REQ-017 digit_idx SHALL advance on each tick, modulo DISPLAYS (DISPLAYS-1 -> 0).
REQ-018 Frame boundary SHALL be defined as a tick occurring while digit_idx=DISPLAYS-1.
REQ-019 load=1 SHALL capture sseg_in into a pending buffer and set pending; repeated loads before a boundary SHALL overwrite the buffer, last write wins.
REQ-020 At a frame boundary with pending=1, the active register SHALL take the pending buffer and pending SHALL clear.
REQ-021 When load=1 coincides with a frame boundary, sseg_in SHALL go directly to the active register and pending SHALL end the cycle at 0.
REQ-022 seg SHALL equal active[digit_idx*SEGMENTS +: SEGMENTS], decoded from registers with no extra latency.
REQ-023 an SHALL enable exactly bit digit_idx while en=1.
REQ-024 The active register SHALL change only at frame boundaries, so no partial frame mixes old and new data.
REQ-025 frame_done SHALL be a registered pulse, high for exactly the one cycle after a boundary tick, i.e. when digit_idx has just returned to 0.
REQ-026 With en=0, the prescaler and digit_idx SHALL hold, all anodes SHALL be inactive, and no tick or frame_done SHALL occur.
REQ-027 With en=0, load SHALL still capture into the pending buffer.
REQ-028 When en returns to 1, the scan SHALL resume from the held count and index.

Reset
REQ-029 While rst_n=0, asynchronously: prescaler=0, digit_idx=0, active register=0, pending buffer=0, pending=0, frame_done=0, an=all inactive, seg=0.
REQ-030 Reset asserted mid-frame SHALL discard any pending update.
REQ-031 The first tick after reset release SHALL occur DIV enabled cycles later.

Verification (DIV=4, DISPLAYS=2, AN_ACTIVE_LOW=1)
REQ-032 Scan timing: reset, en=1 -> an alternates 2'b10 / 2'b01 every 4 cycles; frame_done pulses every 8 cycles, in the cycle where an returns to 2'b10.
REQ-033 Deferred update: load with sseg_in={7'h06,7'h3F} at frame cycle 1 -> pending=1; seg stays 7'h00 until the boundary; next frame shows seg=7'h3F with an=2'b10 and seg=7'h06 with an=2'b01; pending=0.
REQ-034 Last write wins: loads of {7'h5B,7'h4F} then {7'h66,7'h6D} within one frame -> next frame shows 7'h6D for digit 0 and 7'h66 for digit 1 only.
REQ-035 Load on boundary cycle: load={7'h07,7'h7F} on the boundary tick -> digit 0 shows 7'h7F in the following cycle; pending stays 0.
REQ-036 Enable gap: en=0 for 10 cycles at prescaler=2 -> an=2'b11, count and index held; on en=1 the digit changes after exactly 2 more cycles.
REQ-037 Async reset: rst_n low at frame cycle 5 with pending=1 -> without waiting for a clk edge, an=2'b11 and pending=0, frame_done=0; after release, first tick after 4 enabled cycles.
